subtrator_serial_nbits: RTL and testbench

SUBTRATOR_SERIAL_NBITS -- requirements
Module: subtrator_serial_nbits

---
 rtl/subtrator_serial_nbits.sv | 130 +++++++++++++
 tb/tb_subtrator_serial_nbits.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/subtrator_serial_nbits.sv
// Multi-cycle serial subtractor: processes SLICE bits per clock, LSB slice first,
// and publishes s/bout/ovf/zero together with a one-cycle done pulse.
module subtrator_serial_nbits #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int SAFE_SLICE = (SLICE < 1) ? 1 : SLICE;
  localparam int N          = WIDTH / SAFE_SLICE;
  localparam int CW         = $clog2(N + 1);

  generate
    if (WIDTH < 2 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SAFE_SLICE) != 0) begin : g_bad_params
      $error("subtrator_serial_nbits: illegal WIDTH/SLICE combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;
  logic [SLICE:0]   slice_diff;
  logic             last;
  logic             accept;

  assign last   = (cnt == CW'(N - 1));
  assign accept = start && (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // One slice per cycle; the top bit of the difference is the slice borrow.
  always_comb begin
    slice_diff = {1'b0, a_sh[SLICE-1:0]} - {1'b0, b_sh[SLICE-1:0]} - {{SLICE{1'b0}}, borrow};
  end

  // The partial difference is shifted in from the top so it ends up aligned after N slices.
  generate
    if (SLICE == WIDTH) begin : g_single
      assign acc_next = slice_diff[SLICE-1:0];
    end else begin : g_multi
      assign acc_next = {slice_diff[SLICE-1:0], acc[WIDTH-1:SLICE]};
    end
  endgenerate

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = RUN;
        else        next_state = IDLE;
      end
      RUN: begin
        if (last) next_state = DONE;
        else      next_state = RUN;
      end
      DONE: begin
        if (start) next_state = RUN;
        else       next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Operands are held in shift registers; results only update on the final slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      s      <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      a_sh   <= a;
      b_sh   <= b;
      borrow <= bin;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
    end else if (state == RUN) begin
      cnt    <= cnt + CW'(1);
      a_sh   <= a_sh >> SLICE;
      b_sh   <= b_sh >> SLICE;
      borrow <= slice_diff[SLICE];
      acc    <= acc_next;
      if (last) begin
        s    <= acc_next;
        bout <= slice_diff[SLICE];
        ovf  <= (a_msb ^ b_msb) & (a_msb ^ acc_next[WIDTH-1]);
        zero <= (acc_next == '0);
      end else begin
        s    <= s;
      end
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: tb/tb_subtrator_serial_nbits.sv
// Randomized self-checking bench: four instances (SLICE 1,2,4,8) share inputs and
// are compared against an arithmetic reference; directed cases use the SLICE=2 one.
module tb_subtrator_serial_nbits;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       bin = 1'b0;

  logic       busy_v [4];
  logic       done_v [4];
  logic [7:0] s_v    [4];
  logic       bout_v [4];
  logic       ovf_v  [4];
  logic       zero_v [4];

  logic [7:0] prev_s [4];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    subtrator_serial_nbits #(.WIDTH(8), .SLICE(1 << g)) u_dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy_v[g]), .done(done_v[g]), .s(s_v[g]),
      .bout(bout_v[g]), .ovf(ovf_v[g]), .zero(zero_v[g])
    );
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {zero, ovf, bout, s[7:0]} from plain integer arithmetic.
  function automatic logic [10:0] ref_sub(input logic [7:0] ra, input logic [7:0] rb, input logic rbin);
    int full, sa, sb, sd;
    logic [31:0] fv;
    logic [7:0] rs;
    full = int'(ra) - int'(rb) - int'(rbin);
    fv = full;
    rs = fv[7:0];
    sa = (ra >= 8'd128) ? int'(ra) - 256 : int'(ra);
    sb = (rb >= 8'd128) ? int'(rb) - 256 : int'(rb);
    sd = sa - sb - int'(rbin);
    return {(rs == 8'h00), (sd < -128 || sd > 127), (full < 0), rs};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] la, input logic [7:0] lb, input logic lbin);
    @(negedge clk);
    a = la; b = lb; bin = lbin; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called in cycle 1 after the accepting edge; checks all four instances through cycle 9.
  task automatic watch(input logic [7:0] wa, input logic [7:0] wb, input logic wbin);
    logic [10:0] e;
    int n;
    e = ref_sub(wa, wb, wbin);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        n = 8 >> i;
        check_val($sformatf("busy%0d_c%0d", i, cyc), 32'(busy_v[i]), 32'(cyc <= n));
        check_val($sformatf("done%0d_c%0d", i, cyc), 32'(done_v[i]), 32'(cyc == n + 1));
        if (cyc == n + 1) begin
          check_val($sformatf("s%0d", i), 32'(s_v[i]), 32'(e[7:0]));
          check_val($sformatf("bout%0d", i), 32'(bout_v[i]), 32'(e[8]));
          check_val($sformatf("ovf%0d", i), 32'(ovf_v[i]), 32'(e[9]));
          check_val($sformatf("zero%0d", i), 32'(zero_v[i]), 32'(e[10]));
          prev_s[i] = e[7:0];
        end else if (cyc <= n) begin
          check_val($sformatf("s_hold%0d", i), 32'(s_v[i]), 32'(prev_s[i]));
        end
      end
      if (cyc < 9) step();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) prev_s[i] = 8'h00;
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("%s_busy%0d", tag, i), 32'(busy_v[i]), 32'd0);
      check_val($sformatf("%s_done%0d", tag, i), 32'(done_v[i]), 32'd0);
      check_val($sformatf("%s_s%0d", tag, i), 32'(s_v[i]), 32'd0);
      check_val($sformatf("%s_flags%0d", tag, i), 32'({bout_v[i], ovf_v[i], zero_v[i]}), 32'd0);
    end
  endtask

  initial begin
    logic [10:0] e1, e2;
    logic [7:0] ra, rb;
    logic rbin;

    for (int i = 0; i < 4; i++) prev_s[i] = 8'h00;
    step();
    step();
    check_cleared("reset");
    rst = 1'b0;

    // Directed arithmetic corners.
    launch(8'h05, 8'h03, 1'b0); watch(8'h05, 8'h03, 1'b0);
    launch(8'h00, 8'h01, 1'b0); watch(8'h00, 8'h01, 1'b0);
    launch(8'h80, 8'h01, 1'b0); watch(8'h80, 8'h01, 1'b0);
    launch(8'h10, 8'h0F, 1'b1); watch(8'h10, 8'h0F, 1'b1);
    check_val("zero_case_s", 32'(s_v[1]), 32'h00);
    check_val("zero_case_z", 32'(zero_v[1]), 32'd1);
    launch(8'h00, 8'hFF, 1'b1); watch(8'h00, 8'hFF, 1'b1);

    // Start held through RUN, operands changed in cycle 2, restart in the DONE cycle.
    e1 = ref_sub(8'h33, 8'h11, 1'b0);
    e2 = ref_sub(8'hAA, 8'h55, 1'b1);
    @(negedge clk);
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    step();
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc == 2) begin a = 8'hAA; b = 8'h55; bin = 1'b1; end
      if (cyc == 6) start = 1'b0;
      check_val($sformatf("hold_busy_c%0d", cyc), 32'(busy_v[1]),
                32'((cyc >= 1 && cyc <= 4) || (cyc >= 6 && cyc <= 9)));
      check_val($sformatf("hold_done_c%0d", cyc), 32'(done_v[1]), 32'(cyc == 5 || cyc == 10));
      if (cyc == 5)  check_val("hold_s1", 32'(s_v[1]), 32'(e1[7:0]));
      if (cyc == 10) check_val("hold_s2", 32'(s_v[1]), 32'(e2[7:0]));
      step();
    end
    do_reset();
    check_cleared("reset2");

    // Reset during RUN aborts the operation.
    launch(8'h05, 8'h03, 1'b0); watch(8'h05, 8'h03, 1'b0);
    launch(8'h9C, 8'h21, 1'b0);
    step();
    rst = 1'b1;
    step();
    check_val("abort_busy", 32'(busy_v[1]), 32'd0);
    check_val("abort_s", 32'(s_v[1]), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) prev_s[i] = 8'h00;
    for (int cyc = 0; cyc < 10; cyc++) begin
      for (int i = 0; i < 4; i++)
        check_val($sformatf("abort_done%0d_c%0d", i, cyc), 32'(done_v[i]), 32'd0);
      step();
    end

    // Reset wins over a simultaneous start; start is honoured right after.
    @(negedge clk);
    a = 8'h7F; b = 8'hFF; bin = 1'b0; start = 1'b1; rst = 1'b1;
    step();
    check_val("rst_prio_busy", 32'(busy_v[1]), 32'd0);
    rst = 1'b0;
    step();
    start = 1'b0;
    watch(8'h7F, 8'hFF, 1'b0);

    // Random operands, all slice widths in parallel.
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 3))
        0:       ra = 8'h00;
        1:       ra = 8'h80;
        default: ra = 8'($urandom);
      endcase
      rb = (t % 5 == 0) ? ra : 8'($urandom);
      rbin = 1'($urandom);
      launch(ra, rb, rbin);
      watch(ra, rb, rbin);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
